// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit feeder slice.
package uart_pkg;
  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } feeder_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with occupancy count, flags and one-cycle flush.
module uart_sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  // Handshake: a byte transfers on a clock edge where wr_valid and wr_ready are
  // both high; wr_ready comes only from the registered count, so a pop in the
  // same cycle cannot open the port until the following cycle.
  assign push = wr_valid && wr_ready && !flush;
  assign pop  = rd_en && !empty && !flush;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign wr_ready = !full;
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them one at a time to a UART transmitter.
// Optional UART_TX_FEEDER_OVERFLOW_EN adds sticky overflow and a dropped-write count.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic                   flush,
  output logic [DATA_W-1:0]      tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   fifo_empty,
  output logic                   fifo_full,
  output logic                   feeder_idle,
  output feeder_state_t          fsm_state
`ifdef UART_TX_FEEDER_OVERFLOW_EN
  ,
  output logic                   overflow,
  output logic [15:0]            drop_count
`endif
);
  feeder_state_t     state;
  feeder_state_t     state_next;
  logic              pop;
  logic [DATA_W-1:0] head_data;

  uart_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .rd_en    (pop),
    .rd_data  (head_data),
    .flush    (flush),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pop)      state_next = START;
      START:                   state_next = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy)  state_next = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Never pop while the transmitter still reports busy, so tx_start cannot
  // land on top of a frame left over from before a feeder reset.
  always_comb begin
    pop         = (state == IDLE) && !fifo_empty && !tx_busy && !flush;
    tx_start    = (state == START);
    feeder_idle = (state == IDLE) && fifo_empty;
  end

  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      tx_data <= '0;
    else if (pop) tx_data <= head_data;
  end

`ifdef UART_TX_FEEDER_OVERFLOW_EN
  logic drop;
  assign drop = wr_valid && !wr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (flush) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a simple transmitter busy model.
module tb_uart_tx_feeder;
  import uart_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          flush;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic [4:0]    fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          feeder_idle;
  feeder_state_t fsm_state;
`ifdef UART_TX_FEEDER_OVERFLOW_EN
  logic          overflow;
  logic [15:0]   drop_count;
`endif

  int checks = 0;
  int failures = 0;
  int frame_len = 100;
  logic force_busy = 1'b0;
  int busy_cnt;
  int cyc = 0;
  int busy_violations = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int start_cyc[$];

  uart_tx_feeder #(.DEPTH(16), .DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .flush       (flush),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .fifo_count  (fifo_count),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .feeder_idle (feeder_idle),
    .fsm_state   (fsm_state)
`ifdef UART_TX_FEEDER_OVERFLOW_EN
    ,
    .overflow    (overflow),
    .drop_count  (drop_count)
`endif
  );

  // Clock / reset and transmitter model
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Busy rises the cycle after tx_start is sampled and lasts frame_len cycles
  always @(posedge clk or posedge rst) begin
    if (rst)           busy_cnt <= 0;
    else if (tx_start) busy_cnt <= frame_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = force_busy || (busy_cnt != 0);

  always @(negedge clk) begin
    if (!rst && tx_start) begin
      got_q.push_back(tx_data);
      start_cyc.push_back(cyc);
      if (tx_busy) busy_violations++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic clear_hist();
    got_q.delete();
    exp_q.delete();
    start_cyc.delete();
  endtask

  task automatic push_burst(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      wr_data  = first + 8'(i);
      wr_valid = 1'b1;
      @(negedge clk);
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input int n, input int budget, input string name);
    int k = 0;
    while (!(got_q.size() >= n && feeder_idle) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!(got_q.size() >= n && feeder_idle)) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d bytes idle=%0b, need %0d bytes idle=1",
               name, got_q.size(), feeder_idle, n);
    end
  endtask

  // Tests
  task automatic test_reset();
    logic [18:0] obs;
    rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; flush = 1'b0;
    force_busy = 1'b0; frame_len = 100;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    obs = {tx_data, tx_start, fifo_count, fifo_empty, fifo_full, wr_ready, feeder_idle};
    checks++;
    if (obs !== {8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected %h", obs,
               {8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1});
    end
    checks++;
    if (fsm_state !== IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d expected %0d", fsm_state, IDLE);
    end
  endtask

  task automatic test_single();
    clear_hist();
    frame_len = 100;
    wr_data = 8'h55; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    checks++;
    if ({tx_start, fifo_count} !== {1'b0, 5'd1}) begin
      failures++;
      $display("FAIL single_after_push: start/count got %b/%0d expected 0/1", tx_start, fifo_count);
    end
    @(negedge clk);
    checks++;
    if ({tx_start, tx_data, fifo_count} !== {1'b1, 8'h55, 5'd0}) begin
      failures++;
      $display("FAIL single_latency: start/data/count got %b/%h/%0d expected 1/55/0",
               tx_start, tx_data, fifo_count);
    end
    @(negedge clk);
    checks++;
    if ({tx_start, fsm_state} !== {1'b0, WAIT_BUSY}) begin
      failures++;
      $display("FAIL single_pulse_width: start/state got %b/%0d expected 0/%0d",
               tx_start, fsm_state, WAIT_BUSY);
    end
    wait_drain(1, 200, "single");
    checks++;
    if (!(feeder_idle === 1'b1 && got_q.size() == 1 && got_q[0] === 8'h55)) begin
      failures++;
      $display("FAIL single_done: idle=%0b bytes=%0d first=%h expected 1/1/55",
               feeder_idle, got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00);
    end
  endtask

  task automatic test_burst_wrap();
    logic acc;
    int k;
    clear_hist();
    frame_len = 10;
    force_busy = 1'b1;
    push_burst(8'h01, 16);
    checks++;
    if ({fifo_count, fifo_full, wr_ready} !== {5'd16, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL burst_full: count/full/ready got %0d/%b/%b expected 16/1/0",
               fifo_count, fifo_full, wr_ready);
    end
    wr_data = 8'hAA; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    checks++;
    if ({fifo_count, got_q.size() == 0} !== {5'd16, 1'b1}) begin
      failures++;
      $display("FAIL burst_write_at_full: count=%0d bytes=%0d expected 16/0",
               fifo_count, got_q.size());
    end
    // Offer 0x77 on the same cycle the feeder is released to pop
    wr_data = 8'h77; wr_valid = 1'b1; force_busy = 1'b0;
    k = 0;
    do begin
      acc = wr_ready;
      @(negedge clk);
      k++;
    end while (!acc && k < 10);
    wr_valid = 1'b0;
    checks++;
    if ({acc, fifo_count} !== {1'b1, 5'd16}) begin
      failures++;
      $display("FAIL wrap_refill: accepted/count got %b/%0d expected 1/16", acc, fifo_count);
    end
    for (int i = 1; i <= 16; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h77);
    wait_drain(17, 600, "burst");
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL burst_count: got %0d bytes expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL burst_order[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    for (int i = 1; i < start_cyc.size(); i++) begin
      checks++;
      if (start_cyc[i] - start_cyc[i-1] != 13) begin
        failures++;
        $display("FAIL burst_gap[%0d]: got %0d cycles expected 13",
                 i, start_cyc[i] - start_cyc[i-1]);
      end
    end
  endtask

  task automatic test_busy_hold();
    clear_hist();
    frame_len = 10;
    force_busy = 1'b1;
    wr_data = 8'hA1; wr_valid = 1'b1; @(negedge clk);
    wr_data = 8'hB2; @(negedge clk);
    wr_data = 8'hC3; @(negedge clk);
    wr_valid = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if ({got_q.size() == 0, fifo_count} !== {1'b1, 5'd3}) begin
      failures++;
      $display("FAIL busy_hold_quiet: bytes=%0d count=%0d expected 0/3", got_q.size(), fifo_count);
    end
    force_busy = 1'b0;
    exp_q = '{8'hA1, 8'hB2, 8'hC3};
    wait_drain(3, 200, "busy_hold");
    checks++;
    if (got_q.size() != 3) begin
      failures++;
      $display("FAIL busy_hold_count: got %0d bytes expected 3", got_q.size());
    end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL busy_hold_order[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (busy_violations != 0) begin
      failures++;
      $display("FAIL start_while_busy: got %0d expected 0", busy_violations);
    end
  endtask

  task automatic test_flush_wait_done();
    clear_hist();
    frame_len = 10;
    push_burst(8'h31, 6);
    checks++;
    if ({fsm_state, fifo_count} !== {WAIT_DONE, 5'd5}) begin
      failures++;
      $display("FAIL flush_setup: state/count got %0d/%0d expected %0d/5",
               fsm_state, fifo_count, WAIT_DONE);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({fifo_count, fifo_empty, fsm_state} !== {5'd0, 1'b1, WAIT_DONE}) begin
      failures++;
      $display("FAIL flush_clear: count/empty/state got %0d/%b/%0d expected 0/1/%0d",
               fifo_count, fifo_empty, fsm_state, WAIT_DONE);
    end
    wait_drain(1, 100, "flush");
    repeat (20) @(negedge clk);
    checks++;
    if (!(got_q.size() == 1 && got_q[0] === 8'h31 && feeder_idle === 1'b1)) begin
      failures++;
      $display("FAIL flush_after: bytes=%0d first=%h idle=%b expected 1/31/1",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00, feeder_idle);
    end
  endtask

  task automatic test_reset_mid();
    clear_hist();
    frame_len = 10;
    wr_data = 8'h99; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_setup: tx_start got %b expected 1", tx_start);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({tx_start, fsm_state, tx_data} !== {1'b0, IDLE, 8'h00}) begin
      failures++;
      $display("FAIL reset_mid: start/state/data got %b/%0d/%h expected 0/%0d/00",
               tx_start, fsm_state, tx_data, IDLE);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({feeder_idle, wr_ready, fifo_count} !== {1'b1, 1'b1, 5'd0}) begin
      failures++;
      $display("FAIL reset_mid_after: idle/ready/count got %b/%b/%0d expected 1/1/0",
               feeder_idle, wr_ready, fifo_count);
    end
  endtask

`ifdef UART_TX_FEEDER_OVERFLOW_EN
  task automatic test_overflow();
    clear_hist();
    force_busy = 1'b1;
    push_burst(8'h40, 19);
    checks++;
    if ({overflow, drop_count, fifo_count} !== {1'b1, 16'd3, 5'd16}) begin
      failures++;
      $display("FAIL overflow_set: ovf/drops/count got %b/%0d/%0d expected 1/3/16",
               overflow, drop_count, fifo_count);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({overflow, drop_count, fifo_count} !== {1'b0, 16'd0, 5'd0}) begin
      failures++;
      $display("FAIL overflow_flush: ovf/drops/count got %b/%0d/%0d expected 0/0/0",
               overflow, drop_count, fifo_count);
    end
    force_busy = 1'b0;
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_burst_wrap();
    test_busy_hold();
    test_flush_wait_done();
    test_reset_mid();
`ifdef UART_TX_FEEDER_OVERFLOW_EN
    test_overflow();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
